// File: rtl/rv32i_hazard_ctl.sv
// rv32i_hazard_ctl
// ----------------
// Hazard controller sitting between decode (ID) and execute (EX) of the
// rv32i in-order pipeline. A three-slot scoreboard (EX, MEM, WB) remembers
// the destination register of every in-flight instruction. The block
// detects read-after-write hazards for the ID instruction and stalls
// IF/ID while bubbles are pushed into EX. A taken branch flushes the ID
// instruction.
//
// Build option:
//   RV32I_HAZARD_FWD_EN  - when defined, EX/MEM results are forwarded.
//                          Only load-use (one bubble) and, without WB
//                          bypass, WB-slot matches stall. Operand selects
//                          are registered alongside ex_valid_out.
//                          When undefined, every EX/MEM match stalls and
//                          the selects stay at 2'b00.
//
// Parameters:
//   WB_BYPASS      1 = register file is write-through (WB match is safe)
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-high reset
//   id_valid_in    ID holds a valid instruction
//   id_iw_in       instruction word in ID
//   br_taken_in    EX resolved a taken branch/jump this cycle
//   stall_out      hold PC and IF/ID (combinational)
//   flush_out      kill IF/ID contents (combinational, = br_taken_in)
//   ex_valid_out   instruction now in EX is real (registered)
//   fwd_a_sel_out  rs1 source: 00 regfile, 01 MEM result, 10 WB result
//   fwd_b_sel_out  rs2 source, same encoding

module rv32i_hazard_ctl #(
    parameter logic WB_BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid_in,
    input  logic [31:0] id_iw_in,
    input  logic        br_taken_in,
    output logic        stall_out,
    output logic        flush_out,
    output logic        ex_valid_out,
    output logic [1:0]  fwd_a_sel_out,
    output logic [1:0]  fwd_b_sel_out
);

    localparam int NSLOT    = 3;
    localparam int SLOT_EX  = 0;
    localparam int SLOT_MEM = 1;
    localparam int SLOT_WB  = 2;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // ------------------------------------------------------------------
    // ID decode
    // ------------------------------------------------------------------
    logic [6:0] id_opcode;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] id_rd;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       id_writes_rd;

    assign id_opcode = id_iw_in[6:0];
    assign id_rd     = id_iw_in[11:7];
    assign id_rs1    = id_iw_in[19:15];
    assign id_rs2    = id_iw_in[24:20];

    // funct3/funct7 and immediate bits play no part in hazard decisions
    logic unused_iw_bits;
    assign unused_iw_bits = ^{id_iw_in[31:25], id_iw_in[14:12]};

    assign id_uses_rs1  = id_opcode inside {OP_REG, OP_IMM, OP_LOAD,
                                            OP_STORE, OP_BRANCH, OP_JALR};
    assign id_uses_rs2  = id_opcode inside {OP_REG, OP_STORE, OP_BRANCH};
    assign id_writes_rd = id_opcode inside {OP_REG, OP_IMM, OP_LOAD,
                                            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

    // ------------------------------------------------------------------
    // Scoreboard: index 0 = EX, 1 = MEM, 2 = WB
    // ------------------------------------------------------------------
    logic       slot_valid_reg [NSLOT];
    logic [4:0] slot_rd_reg    [NSLOT];

    logic [NSLOT-1:0] match_a;
    logic [NSLOT-1:0] match_b;

    // Source indices of zero never match: x0 is hardwired.
    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_match
            assign match_a[gi] = id_uses_rs1 && (id_rs1 != 5'd0) &&
                                 slot_valid_reg[gi] && (slot_rd_reg[gi] == id_rs1);
            assign match_b[gi] = id_uses_rs2 && (id_rs2 != 5'd0) &&
                                 slot_valid_reg[gi] && (slot_rd_reg[gi] == id_rs2);
        end
    endgenerate

    logic wb_hazard;
    logic hazard;
    logic issue;
    logic [1:0] fwd_a_sel_next;
    logic [1:0] fwd_b_sel_next;

    assign wb_hazard = (WB_BYPASS == 1'b0) && (match_a[SLOT_WB] || match_b[SLOT_WB]);

`ifdef RV32I_HAZARD_FWD_EN
    logic id_is_load;
    logic slot_ex_load_reg;

    assign id_is_load = (id_opcode == OP_LOAD);

    // Only a load in EX cannot be forwarded yet; its data appears one
    // cycle later in MEM and is then picked up via the WB-result path.
    assign hazard = (slot_ex_load_reg && (match_a[SLOT_EX] || match_b[SLOT_EX]))
                    || wb_hazard;

    // Youngest producer wins: EX slot is checked before MEM.
    always_comb begin
        fwd_a_sel_next = 2'b00;
        fwd_b_sel_next = 2'b00;
        if (issue) begin
            if (match_a[SLOT_EX])
                fwd_a_sel_next = 2'b01;
            else if (match_a[SLOT_MEM])
                fwd_a_sel_next = 2'b10;
            if (match_b[SLOT_EX])
                fwd_b_sel_next = 2'b01;
            else if (match_b[SLOT_MEM])
                fwd_b_sel_next = 2'b10;
        end
    end

    // The load flag is only consulted for the EX slot, so it is not
    // carried further down the scoreboard.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            slot_ex_load_reg <= 1'b0;
        else
            slot_ex_load_reg <= issue && id_is_load;
    end
`else
    assign hazard = match_a[SLOT_EX] || match_a[SLOT_MEM] ||
                    match_b[SLOT_EX] || match_b[SLOT_MEM] || wb_hazard;

    assign fwd_a_sel_next = 2'b00;
    assign fwd_b_sel_next = 2'b00;
`endif

    // Flush dominates stall: a killed instruction must not hold the front end.
    assign issue     = id_valid_in && !br_taken_in && !hazard;
    assign stall_out = id_valid_in && hazard && !br_taken_in;
    assign flush_out = br_taken_in;

    // ------------------------------------------------------------------
    // Scoreboard update
    // ------------------------------------------------------------------
    // EX slot takes the ID decode on issue; otherwise a bubble enters.
    // rd = x0 results are never tracked, so they can never stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_valid_reg[SLOT_EX] <= 1'b0;
            slot_rd_reg[SLOT_EX]    <= 5'd0;
            ex_valid_out            <= 1'b0;
            fwd_a_sel_out           <= 2'b00;
            fwd_b_sel_out           <= 2'b00;
        end else begin
            slot_valid_reg[SLOT_EX] <= issue && id_writes_rd && (id_rd != 5'd0);
            slot_rd_reg[SLOT_EX]    <= id_rd;
            ex_valid_out            <= issue;
            fwd_a_sel_out           <= fwd_a_sel_next;
            fwd_b_sel_out           <= fwd_b_sel_next;
        end
    end

    // Older slots shift unconditionally: EX->MEM, MEM->WB, WB retires.
    generate
        for (genvar gi = 1; gi < NSLOT; gi++) begin : g_shift
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    slot_valid_reg[gi] <= 1'b0;
                    slot_rd_reg[gi]    <= 5'd0;
                end else begin
                    slot_valid_reg[gi] <= slot_valid_reg[gi-1];
                    slot_rd_reg[gi]    <= slot_rd_reg[gi-1];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_rv32i_hazard_ctl.sv
// Self-checking bench for rv32i_hazard_ctl. The reference model keeps a
// history of the instruction words issued 1, 2 and 3 cycles ago and applies
// the read-after-write distance rules directly to those words.
`timescale 1ns/1ps

module tb_rv32i_hazard_ctl;

    localparam logic WB_BYP = 1'b0;

    localparam logic [31:0] I_ADDI_X5 = 32'h00100293; // addi x5,x0,1
    localparam logic [31:0] I_ADD_X6  = 32'h00528333; // add  x6,x5,x5
    localparam logic [31:0] I_LW_X5   = 32'h0000A283; // lw   x5,0(x1)
    localparam logic [31:0] I_NOP     = 32'h00000013; // addi x0,x0,0

`ifdef RV32I_HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_iw;
    logic        br_taken;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [1:0]  fwd_a;
    logic [1:0]  fwd_b;

    int n_pass  = 0;
    int n_total = 0;

    // history of issued instructions, index = cycles ago (1..3)
    bit          hv [1:3];
    logic [31:0] hw [1:3];

    // last observations from step()
    logic obs_stall;
    logic obs_ex_valid;
    logic [1:0] obs_a;
    logic [1:0] obs_b;

    always #5 clk = ~clk;

    rv32i_hazard_ctl #(.WB_BYPASS(WB_BYP)) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid_in   (id_valid),
        .id_iw_in      (id_iw),
        .br_taken_in   (br_taken),
        .stall_out     (stall),
        .flush_out     (flush),
        .ex_valid_out  (ex_valid),
        .fwd_a_sel_out (fwd_a),
        .fwd_b_sel_out (fwd_b)
    );

    // ---------------- reference model ----------------
    function automatic bit m_uses1(input logic [31:0] w);
        return w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011,
                              7'b0100011, 7'b1100011, 7'b1100111};
    endfunction
    function automatic bit m_uses2(input logic [31:0] w);
        return w[6:0] inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction
    function automatic bit m_writes(input logic [31:0] w);
        return (w[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111,
                               7'b0010111, 7'b1101111, 7'b1100111}) && (w[11:7] != 5'd0);
    endfunction
    function automatic bit m_load(input logic [31:0] w);
        return w[6:0] == 7'b0000011;
    endfunction

    // Evaluate one source register against the issue history.
    task automatic m_source(input logic [4:0] src, input bit used,
                            output bit haz, output logic [1:0] sel);
        bit found;
        haz   = 1'b0;
        sel   = 2'b00;
        found = 1'b0;
        for (int d = 1; d <= 3; d++) begin
            if (used && src != 5'd0 && hv[d] && m_writes(hw[d]) && hw[d][11:7] == src) begin
                if (!FWD)
                    haz |= (d < 3) || !WB_BYP;
                else
                    haz |= (d == 1 && m_load(hw[d])) || (d == 3 && !WB_BYP);
                if (!found && FWD)
                    sel = (d == 1) ? 2'b01 : (d == 2) ? 2'b10 : 2'b00;
                found = 1'b1;
            end
        end
    endtask

    task automatic m_clear();
        for (int d = 1; d <= 3; d++) begin
            hv[d] = 1'b0;
            hw[d] = 32'h0;
        end
    endtask

    // One cycle: drive ID, check combinational outputs, clock, check EX.
    task automatic step(input logic v, input logic [31:0] iw, input logic br);
        bit ha, hb, iss;
        logic [1:0] sa, sb, ea, eb;
        logic exp_stall;
        id_valid = v;
        id_iw    = iw;
        br_taken = br;
        m_source(iw[19:15], m_uses1(iw), ha, sa);
        m_source(iw[24:20], m_uses2(iw), hb, sb);
        exp_stall = v && (ha || hb) && !br;
        iss = v && !br && !(ha || hb);
        ea = iss ? sa : 2'b00;
        eb = iss ? sb : 2'b00;
        #1;
        obs_stall = stall;
        n_total++;
        if (stall !== exp_stall)
            $display("FAIL stall_out iw=%08h: got %b expected %b", iw, stall, exp_stall);
        else n_pass++;
        n_total++;
        if (flush !== br)
            $display("FAIL flush_out iw=%08h: got %b expected %b", iw, flush, br);
        else n_pass++;
        @(posedge clk);
        #1;
        obs_ex_valid = ex_valid;
        obs_a = fwd_a;
        obs_b = fwd_b;
        n_total++;
        if (ex_valid !== iss)
            $display("FAIL ex_valid_out iw=%08h: got %b expected %b", iw, ex_valid, iss);
        else n_pass++;
        n_total++;
        if (fwd_a !== ea)
            $display("FAIL fwd_a_sel_out iw=%08h: got %b expected %b", iw, fwd_a, ea);
        else n_pass++;
        n_total++;
        if (fwd_b !== eb)
            $display("FAIL fwd_b_sel_out iw=%08h: got %b expected %b", iw, fwd_b, eb);
        else n_pass++;
        hv[3] = hv[2]; hw[3] = hw[2];
        hv[2] = hv[1]; hw[2] = hw[1];
        hv[1] = iss;   hw[1] = iw;
        $display("txn v=%0b iw=%08h br=%0b stall=%0b ex_valid=%0b a=%0b b=%0b",
                 v, iw, br, obs_stall, ex_valid, fwd_a, fwd_b);
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0);
    endtask

    // Present iw until it issues (bounded); reports stalls seen.
    task automatic issue_until(input logic [31:0] iw, output int stalls, output bit issued);
        stalls = 0;
        issued = 1'b0;
        for (int i = 0; i < 6 && !issued; i++) begin
            step(1'b1, iw, 1'b0);
            if (obs_stall) stalls++;
            issued = obs_ex_valid;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; id_valid = 1'b0; id_iw = 32'h0; br_taken = 1'b0;
        m_clear();
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (ex_valid !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00)
            $display("FAIL reset_regs: got ev=%b a=%b b=%b expected 0/00/00", ex_valid, fwd_a, fwd_b);
        else n_pass++;
        id_valid = 1'b1; id_iw = I_ADD_X6; br_taken = 1'b1;
        #1;
        n_total++;
        if (stall !== 1'b0 || flush !== 1'b1)
            $display("FAIL reset_comb: got stall=%b flush=%b expected 0/1", stall, flush);
        else n_pass++;
        br_taken = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, I_ADDI_X5, 1'b0);
        n_total++;
        if (obs_stall !== 1'b0 || obs_ex_valid !== 1'b1 || obs_a !== 2'b00 || obs_b !== 2'b00)
            $display("FAIL first_issue: got stall=%b ev=%b a=%b b=%b expected 0/1/00/00",
                     obs_stall, obs_ex_valid, obs_a, obs_b);
        else n_pass++;
        drain();
    endtask

    task automatic test_raw();
        int st; bit ok;
        logic [1:0] es;
        es = FWD ? 2'b01 : 2'b00;
        step(1'b1, I_ADDI_X5, 1'b0);
        issue_until(I_ADD_X6, st, ok);
        n_total++;
        if (!ok || st != (FWD ? 0 : 3))
            $display("FAIL raw_stalls: got issued=%0b stalls=%0d expected 1/%0d", ok, st, FWD ? 0 : 3);
        else n_pass++;
        n_total++;
        if (obs_a !== es || obs_b !== es)
            $display("FAIL raw_sel: got a=%b b=%b expected %b", obs_a, obs_b, es);
        else n_pass++;
        drain();
    endtask

    task automatic test_load_use();
        int st; bit ok;
        logic [1:0] es;
        es = FWD ? 2'b10 : 2'b00;
        step(1'b1, I_LW_X5, 1'b0);
        issue_until(I_ADD_X6, st, ok);
        n_total++;
        if (!ok || st != (FWD ? 1 : 3))
            $display("FAIL load_use_stalls: got issued=%0b stalls=%0d expected 1/%0d", ok, st, FWD ? 1 : 3);
        else n_pass++;
        n_total++;
        if (obs_a !== es || obs_b !== es)
            $display("FAIL load_use_sel: got a=%b b=%b expected %b", obs_a, obs_b, es);
        else n_pass++;
        drain();
    endtask

    task automatic test_flush_and_x0();
        step(1'b1, I_LW_X5, 1'b0);
        step(1'b1, I_ADD_X6, 1'b0);
        n_total++;
        if (obs_stall !== 1'b1)
            $display("FAIL flush_setup_stall: got %b expected 1", obs_stall);
        else n_pass++;
        step(1'b1, I_ADD_X6, 1'b1);
        n_total++;
        if (obs_stall !== 1'b0 || obs_ex_valid !== 1'b0)
            $display("FAIL flush_prio: got stall=%b ev=%b expected 0/0", obs_stall, obs_ex_valid);
        else n_pass++;
        drain();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, I_NOP, 1'b0);
            n_total++;
            if (obs_stall !== 1'b0 || obs_ex_valid !== 1'b1)
                $display("FAIL x0_nostall: got stall=%b ev=%b expected 0/1", obs_stall, obs_ex_valid);
            else n_pass++;
        end
        drain();
    endtask

    task automatic test_async_reset();
        step(1'b1, I_LW_X5, 1'b0);
        id_valid = 1'b1; id_iw = I_ADD_X6; br_taken = 1'b0;
        #1;
        n_total++;
        if (stall !== 1'b1 || ex_valid !== 1'b1)
            $display("FAIL areset_setup: got stall=%b ev=%b expected 1/1", stall, ex_valid);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (ex_valid !== 1'b0 || fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0)
            $display("FAIL areset_immediate: got ev=%b a=%b b=%b stall=%b expected 0/00/00/0",
                     ex_valid, fwd_a, fwd_b, stall);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (ex_valid !== 1'b0)
            $display("FAIL areset_held: got ev=%b expected 0", ex_valid);
        else n_pass++;
        reset = 1'b0;
        m_clear();
        step(1'b1, I_ADD_X6, 1'b0);
        n_total++;
        if (obs_ex_valid !== 1'b1 || obs_a !== 2'b00 || obs_b !== 2'b00)
            $display("FAIL areset_release_issue: got ev=%b a=%b b=%b expected 1/00/00",
                     obs_ex_valid, obs_a, obs_b);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        logic [6:0] ops [9];
        logic [31:0] iw;
        logic v, br;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1100111, 7'b0110111, 7'b1101111, 7'b0000000};
        iw = 32'h0;
        obs_stall = 1'b0;
        for (int i = 0; i < 300; i++) begin
            // A stalled instruction stays in ID, as the front end would hold it.
            if (!(obs_stall && v)) begin
                iw = {7'b0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 3'b010,
                      5'($urandom_range(0, 3)), ops[$urandom_range(0, 8)]};
                v = ($urandom_range(0, 7) != 0);
            end
            br = ($urandom_range(0, 9) == 0);
            step(v, iw, br);
        end
        drain();
    endtask

    initial begin
        v_init: begin end
        test_reset();
        test_raw();
        test_load_use();
        test_flush_and_x0();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    logic v;

endmodule
